// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with a 2-entry skid buffer and a flop-driven in_ready.
// Define PIPE_SKID_STAGE_PERF_EN to add the stall_cnt / flush_drop_cnt performance counters.
module pipe_skid_stage #(
    parameter int DATA_W       = 32,
    parameter bit CLR_ON_FLUSH = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_drop_cnt
`endif
);

    // Encoding is the pair of valid flops: bit1 = skid valid, bit0 = main valid.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic              inReady_q;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              inFire, outFire;

    assign in_ready  = inReady_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign inFire    = in_valid & inReady_q;
    assign outFire   = out_valid & out_ready;

    // Next-state and data-path steering; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (inFire) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (inFire && outFire) begin
                    main_d = in_data;
                end else if (inFire) begin
                    state_d = TWO;
                    skid_d  = in_data;
                end else if (outFire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (outFire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            if (CLR_ON_FLUSH) begin
                main_d = '0;
                skid_d = '0;
            end
        end
    end

    // in_ready is registered from the next state so the allowin path stays local.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            inReady_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            inReady_q <= (state_d != TWO);
        end
    end

    always_ff @(posedge clk) begin
        if (CLR_ON_FLUSH && reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

`ifdef PIPE_SKID_STAGE_PERF_EN
    logic [31:0] stallCnt_q;
    logic [31:0] dropCnt_q;
    logic [31:0] dropInc;

    // Entries lost to a flush: held ones not taken downstream, plus any same-cycle arrival.
    always_comb begin
        dropInc = 32'(out_valid) + 32'(state_q == TWO) - 32'(outFire) + 32'(inFire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt_q <= '0;
            dropCnt_q  <= '0;
        end else begin
            stallCnt_q <= stallCnt_q + 32'(out_valid & ~out_ready);
            if (flush) begin
                dropCnt_q <= dropCnt_q + dropInc;
            end
        end
    end

    assign stall_cnt      = stallCnt_q;
    assign flush_drop_cnt = dropCnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: table vectors, hand-written corner sequences and randomized traffic
// checked against a queue-based model of the skid stage (CLR_ON_FLUSH = 1).
module tb_pipe_skid_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef PIPE_SKID_STAGE_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_drop_cnt;
`endif

    int compared = 0;
    int mismatched = 0;

    pipe_skid_stage #(
        .DATA_W       (32),
        .CLR_ON_FLUSH (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_SKID_STAGE_PERF_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_drop_cnt (flush_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an ordered queue of accepted payloads, capacity two.
    logic [31:0] modelQ[$];
    logic        inReadyM = 1'b1;
    logic        zeroedM = 1'b1;
    logic [31:0] stallM = 0;
    logic [31:0] dropM = 0;

    typedef struct {
        logic        iv;
        logic [31:0] data;
        logic        ordy;
        logic        expValid;
        logic        expReady;
        logic [31:0] expData;
        logic        chkData;
    } vec_t;

    vec_t vecs[$];

    // Drive one cycle of inputs, let the edge happen, and advance the model alongside.
    task automatic applyStimulus(input logic iv, input logic [31:0] d, input logic ordy,
                                 input logic fl, input logic rst);
        logic inFireM, outFireM;
        int   held;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        held      = modelQ.size();
        inFireM   = iv && inReadyM;
        outFireM  = (held > 0) && ordy;
        @(posedge clk);
        if (rst) begin
            modelQ.delete();
            inReadyM = 1'b1;
            zeroedM  = 1'b1;
            stallM   = 0;
            dropM    = 0;
        end else begin
            if (held > 0 && !ordy) stallM = stallM + 1;
            if (fl) dropM = dropM + 32'(held) - 32'(outFireM) + 32'(inFireM);
            if (outFireM) void'(modelQ.pop_front());
            if (fl) begin
                modelQ.delete();
                zeroedM = 1'b1;
            end else if (inFireM) begin
                modelQ.push_back(d);
                zeroedM = 1'b0;
            end
            inReadyM = (modelQ.size() < 2);
        end
        #1;
    endtask

    task automatic checkOutput(input string name, input logic expV, input logic expR,
                               input logic [31:0] expD, input logic chkD);
        compared++;
        if (out_valid !== expV || in_ready !== expR || (chkD && out_data !== expD)) begin
            mismatched++;
            $display("[TB] FAIL %s: got valid=%0b ready=%0b data=%h, want valid=%0b ready=%0b data=%h",
                     name, out_valid, in_ready, out_data, expV, expR, expD);
        end
    endtask

    task automatic checkModel(input string name);
        logic        expV;
        logic [31:0] expD;
        expV = (modelQ.size() > 0);
        expD = expV ? modelQ[0] : 32'h0;
        checkOutput(name, expV, inReadyM, expD, expV || zeroedM);
`ifdef PIPE_SKID_STAGE_PERF_EN
        checkCounter({name, "_stall"}, stall_cnt, stallM);
        checkCounter({name, "_drop"}, flush_drop_cnt, dropM);
`endif
    endtask

    task automatic checkCounter(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        reset     = 1'b1;

        // Streaming, backpressure fill and simultaneous in/out vectors (outputs after the edge).
        for (int i = 1; i <= 8; i++)
            vecs.push_back('{1'b1, 32'(i), 1'b1, 1'b1, 1'b1, 32'(i), 1'b1});
        vecs.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 32'hA, 1'b0, 1'b1, 1'b1, 32'hA, 1'b1});
        vecs.push_back('{1'b1, 32'hB, 1'b0, 1'b1, 1'b0, 32'hA, 1'b1});
        vecs.push_back('{1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 32'hA, 1'b1});
        vecs.push_back('{1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 32'hB, 1'b1});
        vecs.push_back('{1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 32'hC, 1'b1});
        vecs.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 32'h5, 1'b0, 1'b1, 1'b1, 32'h5, 1'b1});
        vecs.push_back('{1'b1, 32'h6, 1'b1, 1'b1, 1'b1, 32'h6, 1'b1});
        vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h6, 1'b1});
        vecs.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0});

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_state", 1'b0, 1'b1, 32'h0, 1'b1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].iv, vecs[i].data, vecs[i].ordy, 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expReady,
                        vecs[i].expData, vecs[i].chkData);
        end

        // Flush while full with a refused arrival pending.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        checkOutput("fill_two", 1'b1, 1'b0, 32'h11, 1'b1);
        applyStimulus(1'b1, 32'h33, 1'b0, 1'b1, 1'b0);
        checkOutput("flush_two", 1'b0, 1'b1, 32'h0, 1'b1);
`ifdef PIPE_SKID_STAGE_PERF_EN
        checkCounter("flush_drop_two", flush_drop_cnt, 32'd2);
`endif
        applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
        checkOutput("after_flush_push", 1'b1, 1'b1, 32'h44, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("after_flush_drain", 1'b0, 1'b1, 32'h0, 1'b0);

        // Reset in the middle of a stalled stream.
        applyStimulus(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h3, 1'b0, 1'b0, 1'b0);
        checkOutput("stalled_three", 1'b1, 1'b0, 32'h1, 1'b1);
        applyStimulus(1'b1, 32'h99, 1'b0, 1'b0, 1'b1);
        checkOutput("mid_reset", 1'b0, 1'b1, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        checkOutput("push_after_reset", 1'b1, 1'b1, 32'h77, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("drain_after_reset", 1'b0, 1'b1, 32'h0, 1'b0);

`ifdef PIPE_SKID_STAGE_PERF_EN
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h5A, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkCounter("stall_ten", stall_cnt, 32'd10);
        dut.stallCnt_q = 32'hFFFF_FFFF;
        stallM = 32'hFFFF_FFFF;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkCounter("stall_wrap", stall_cnt, 32'd0);
`endif

        // Randomized traffic against the queue model.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
            checkModel($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Parametrised pipeline-stage register with a valid/ready handshake and a built-in 2-entry skid buffer.
- Used between any two CPU pipeline stages (e.g. M->W). Payload is a flat bus packed by the instantiating stage.
- Supports full throughput with a registered in_ready, which breaks the combinational allowin chain.
- Flush input kills all held contents for exception/eret response.

Parameters:
DATA_W, 32, payload width in bits (1..512)
CLR_ON_FLUSH, 0, 1 = data registers zeroed on reset/flush; 0 = data registers untouched (only valid bits cleared)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous kill of all held and incoming entries
in_valid  input  1  upstream has an entry
in_ready  output  1  stage can accept; driven directly from a flop
in_data  input  DATA_W  upstream payload
out_valid  output  1  stage holds an entry for downstream
out_ready  input  1  downstream accepts (allowin)
out_data  output  DATA_W  payload of the oldest held entry

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Storage: main register (presented on out_data) and skid register.
- State machine, encoded as two valid flops:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - TWO: main valid, skid valid.
- Outputs per state:
  - out_valid = (state != EMPTY).
  - in_ready flop = 1 in EMPTY/ONE, 0 in TWO; it updates with the next-state value.
- EMPTY transitions:
  - in_fire -> ONE, main <= in_data.
  - else stay.
- ONE transitions:
  - in_fire & out_fire -> ONE, main <= in_data.
  - in_fire & !out_fire -> TWO, skid <= in_data.
  - !in_fire & out_fire -> EMPTY.
  - neither -> stay.
- TWO transitions:
  - out_fire -> ONE, main <= skid.
  - else stay. in_fire is impossible because in_ready = 0.
- Latency and throughput:
  - Latency: in_fire at cycle N -> out_valid with that data at N+1, when the stage was empty or draining.
  - Throughput: 1 entry/cycle sustained while out_ready = 1.
- Ordering: strict FIFO, never reorders, never duplicates, never drops except on flush/reset.
- out_data stays stable while out_valid & !out_ready.
- Flush:
  - Highest priority after reset. Next state is EMPTY and in_ready = 1.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as consumed by downstream (that entry was taken).
- Reset values:
  - Both valid flops 0, so out_valid = 0.
  - in_ready = 1.
  - Data registers 0 if CLR_ON_FLUSH = 1, else unspecified (X allowed). Same rule applies on flush.
- Reset mid-operation: behaves exactly as flush; held entries are lost.
- in_valid may be asserted while in_ready = 0; in_data is ignored that cycle.

Optional Feature:
Macro PIPE_SKID_STAGE_PERF_EN.
- When defined, two extra outputs are present:
  - stall_cnt [31:0]: increments each cycle with out_valid & !out_ready, wraps 0xFFFFFFFF -> 0.
  - flush_drop_cnt [31:0]: on a flush cycle, adds the number of valid entries held that are not out_fire'd in that cycle (0, 1 or 2), plus 1 if in_fire. Wraps modulo 2^32.
  - Both counters are cleared by reset only.
- When not defined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
1. Streaming: DATA_W = 32, out_ready = 1, feed in_data 0x1..0x8 back-to-back -> out_data 0x1..0x8 on consecutive cycles, one cycle later; in_ready stays 1.
2. Backpressure fill: out_ready = 0, push 0xA then 0xB -> state TWO, in_ready = 0 the cycle after 0xB; a 0xC held on in_valid is not taken. Then raise out_ready -> out 0xA, 0xB, 0xC in order with no loss.
3. Simultaneous in/out in ONE: main = 0x5, in 0x6 with out_ready = 1 -> 0x5 consumed, next cycle out_data = 0x6, state ONE.
4. Flush in TWO with in_valid = 1 (in_ready = 0) -> next cycle out_valid = 0, in_ready = 1. With CLR_ON_FLUSH = 1, out_data = 0. With PERF_EN, flush_drop_cnt += 2.
5. Reset mid-stream after 3 pushes with out_ready = 0 -> out_valid = 0, in_ready = 1. A fresh push of 0x77 emerges next cycle as out_data = 0x77.
6. PERF_EN: hold out_valid with out_ready = 0 for 10 cycles -> stall_cnt = 10. Preload stall_cnt to 0xFFFFFFFF, one more stall cycle -> 0.
